// File: rtl/vram_console.sv
// Text-console writer: turns a byte stream into 40x30 character VRAM writes and clears.
// Latency: one cycle from byte acceptance to the VRAM write pulse; all outputs registered.
// Backpressure: in_ready is high only in IDLE and drops while a screen or line clear runs.
module vram_console #(
  parameter int          COLS  = 40,
  parameter int          ROWS  = 30,
  parameter int          AW    = 11,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] vram_waddr,
  output logic [7:0]    vram_wdata,
  output logic          vram_we,
  output logic [4:0]    cur_row,
  output logic [5:0]    cur_col,
  output logic          busy
);

  typedef enum logic [1:0] {
    CLR_SCREEN,
    CLR_LINE,
    IDLE
  } state_t;

  localparam logic [AW-1:0] LAST_CELL = AW'(COLS * ROWS - 1);
  localparam logic [AW-1:0] LAST_FILL_COL = AW'(COLS - 1);
  localparam logic [5:0]    LAST_COL  = 6'(COLS - 1);
  localparam logic [4:0]    LAST_ROW  = 5'(ROWS - 1);

  // Linear cell address; the product never exceeds COLS*ROWS-1, so AW bits suffice.
  function automatic logic [AW-1:0] addr_of(input logic [4:0] row, input logic [5:0] col);
    return AW'(row) * AW'(COLS) + AW'(col);
  endfunction

  state_t        state_q, state_d;
  logic [AW-1:0] fill_q, fill_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [4:0]    row_q, row_d;
  logic [5:0]    col_q, col_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic          accept;
  logic          advance;

  // Next-state and registered-output computation for the clear sequencer and byte decoder.
  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    row_d      = row_q;
    col_d      = col_q;
    in_ready_d = in_ready_q;
    busy_d     = busy_q;
    advance    = 1'b0;
    accept     = in_valid && in_ready_q;

    case (state_q)
      CLR_SCREEN: begin
        we_d    = 1'b1;
        waddr_d = fill_q;
        wdata_d = BLANK;
        fill_d  = fill_q + 1'b1;
        if (fill_q == LAST_CELL) begin
          state_d    = IDLE;
          fill_d     = '0;
          row_d      = '0;
          col_d      = '0;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
      end

      CLR_LINE: begin
        we_d    = 1'b1;
        waddr_d = addr_of(row_q, fill_q[5:0]);
        wdata_d = BLANK;
        fill_d  = fill_q + 1'b1;
        if (fill_q == LAST_FILL_COL) begin
          state_d    = IDLE;
          fill_d     = '0;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
      end

      IDLE: begin
        if (accept) begin
          if (in_data >= 8'h20) begin
            we_d    = 1'b1;
            waddr_d = addr_of(row_q, col_q);
            wdata_d = in_data;
            if (col_q == LAST_COL) begin
              col_d   = '0;
              advance = 1'b1;
            end else begin
              col_d = col_q + 6'd1;
            end
          end else if (in_data == 8'h0D) begin
            col_d = '0;
          end else if (in_data == 8'h0A) begin
            advance = 1'b1;
          end else if (in_data == 8'h08) begin
            if (col_q != 6'd0) begin
              col_d = col_q - 6'd1;
            end
          end else if (in_data == 8'h0C) begin
            state_d    = CLR_SCREEN;
            fill_d     = '0;
            in_ready_d = 1'b0;
            busy_d     = 1'b1;
          end
        end

        // Moving past the bottom row scrolls nothing: it wraps to row 0 and blanks it first.
        if (advance) begin
          if (row_q != LAST_ROW) begin
            row_d = row_q + 5'd1;
          end else begin
            row_d      = '0;
            col_d      = '0;
            state_d    = CLR_LINE;
            fill_d     = '0;
            in_ready_d = 1'b0;
            busy_d     = 1'b1;
          end
        end
      end

      default: begin
        state_d    = CLR_SCREEN;
        fill_d     = '0;
        in_ready_d = 1'b0;
        busy_d     = 1'b1;
      end
    endcase
  end

  // State and output registers; reset restarts the full-screen clear from address 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CLR_SCREEN;
      fill_q     <= '0;
      waddr_q    <= '0;
      wdata_q    <= BLANK;
      we_q       <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      row_q      <= row_d;
      col_q      <= col_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign vram_waddr = waddr_q;
  assign vram_wdata = wdata_q;
  assign vram_we    = we_q;
  assign cur_row    = row_q;
  assign cur_col    = col_q;
  assign in_ready   = in_ready_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_vram_console.sv
// Bench for vram_console: write stream checked against a queue of expected (addr, data) pairs.
// A cursor model in the bench predicts every write and clear triggered by each sent byte.
// Per-scenario tasks also check cursor, handshake and timing at the points of interest.
module tb_vram_console;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] vram_waddr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic [4:0]  cur_row;
  logic [5:0]  cur_col;
  logic        busy;

  vram_console dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .vram_waddr(vram_waddr), .vram_wdata(vram_wdata), .vram_we(vram_we),
    .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int m_row = 0;
  int m_col = 0;
  logic [18:0] exp_q[$];
  int cyc = 0;
  int wr_count = 0;
  int first_wr = 0;
  int last_wr = 0;

  // Write monitor: every VRAM write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [18:0] e;
    cyc++;
    if (vram_we === 1'b1) begin
      if (wr_count == 0) first_wr = cyc;
      last_wr = cyc;
      wr_count++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", vram_waddr, vram_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({vram_waddr, vram_wdata} !== e) begin
          bad++;
          $display("FAIL vram_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   vram_waddr, vram_wdata, e[18:8], e[7:0]);
        end
      end
    end
  end

  task automatic push_screen();
    for (int i = 0; i < 1200; i++) exp_q.push_back({11'(i), 8'h20});
  endtask

  task automatic m_advance();
    if (m_row < 29) begin
      m_row++;
    end else begin
      m_row = 0;
      m_col = 0;
      for (int i = 0; i < 40; i++) exp_q.push_back({11'(i), 8'h20});
    end
  endtask

  // Predict the effect of byte b, then present it for exactly one accepting edge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    while (in_ready !== 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
    end
    if (b >= 8'h20) begin
      exp_q.push_back({11'(m_row * 40 + m_col), b});
      if (m_col == 39) begin
        m_col = 0;
        m_advance();
      end else begin
        m_col++;
      end
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      m_advance();
    end else if (b == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (b == 8'h0C) begin
      push_screen();
      m_row = 0;
      m_col = 0;
    end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (in_ready !== 1'b1 && n < 2500) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL idle_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
    end
    @(negedge clk); #1;
  endtask

  task automatic drain();
    @(posedge clk); @(negedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (vram_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b expected 0", vram_we); end
    total++; if (vram_waddr !== 11'd0) begin bad++; $display("FAIL rst_waddr: got %0d expected 0", vram_waddr); end
    total++; if (vram_wdata !== 8'h20) begin bad++; $display("FAIL rst_wdata: got %h expected 20", vram_wdata); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b expected 0", in_ready); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy: got %b expected 1", busy); end
    total++; if ({cur_row, cur_col} !== 11'd0) begin bad++; $display("FAIL rst_cursor: got (%0d,%0d) expected (0,0)", cur_row, cur_col); end
    push_screen();
    wr_count = 0;
    reset = 1'b0;
    wait_idle();
    total++; if (wr_count !== 1200) begin bad++; $display("FAIL init_count: got %0d expected 1200", wr_count); end
    total++; if (last_wr - first_wr !== 1199) begin bad++; $display("FAIL init_contig: got span %0d expected 1199", last_wr - first_wr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL init_busy: got %b expected 0", busy); end
    total++; if ({cur_row, cur_col} !== 11'd0) begin bad++; $display("FAIL init_cursor: got (%0d,%0d) expected (0,0)", cur_row, cur_col); end
  endtask

  task automatic test_back_to_back();
    wr_count = 0;
    send(8'h48);
    send(8'h69);
    drain();
    total++; if (wr_count !== 2) begin bad++; $display("FAIL hi_count: got %0d expected 2", wr_count); end
    total++; if (last_wr - first_wr !== 1) begin bad++; $display("FAIL hi_consecutive: got gap %0d expected 1", last_wr - first_wr); end
    total++; if (cur_row !== 5'd0 || cur_col !== 6'd2) begin bad++; $display("FAIL hi_cursor: got (%0d,%0d) expected (0,2)", cur_row, cur_col); end
  endtask

  task automatic test_line_wrap();
    send(8'h0C);
    wait_idle();
    wr_count = 0;
    for (int i = 0; i < 41; i++) send(8'h41);
    drain();
    total++; if (wr_count !== 41) begin bad++; $display("FAIL row_wrap_count: got %0d expected 41", wr_count); end
    total++; if (cur_row !== 5'd1 || cur_col !== 6'd1) begin bad++; $display("FAIL row_wrap_cursor: got (%0d,%0d) expected (1,1)", cur_row, cur_col); end
    total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL row_wrap_noclear: got busy=%b ready=%b expected 0/1", busy, in_ready); end
  endtask

  task automatic test_controls();
    send(8'h0C);
    wait_idle();
    send(8'h41); send(8'h42); send(8'h0D); send(8'h0A); send(8'h43);
    drain();
    total++; if (cur_row !== 5'd1 || cur_col !== 6'd1) begin bad++; $display("FAIL crlf_cursor: got (%0d,%0d) expected (1,1)", cur_row, cur_col); end
    send(8'h0D); send(8'h08); send(8'h01);
    drain();
    total++; if (cur_row !== 5'd1 || cur_col !== 6'd0) begin bad++; $display("FAIL bs_col0: got (%0d,%0d) expected (1,0)", cur_row, cur_col); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL ctl_pending: got %0d writes missing expected 0", exp_q.size()); end
  endtask

  task automatic test_lf_bottom();
    int n = 0;
    send(8'h58); send(8'h59);
    for (int i = 0; i < 28; i++) send(8'h0A);
    drain();
    total++; if (cur_row !== 5'd29 || cur_col !== 6'd2) begin bad++; $display("FAIL lf_pos: got (%0d,%0d) expected (29,2)", cur_row, cur_col); end
    send(8'h0A);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL lf_busy: got %b expected 1", busy); end
    while (in_ready !== 1'b1 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    total++; if (n !== 40) begin bad++; $display("FAIL lf_ready_low: got %0d cycles expected 40", n); end
    @(negedge clk); #1;
    total++; if (cur_row !== 5'd0 || cur_col !== 6'd0) begin bad++; $display("FAIL lf_cursor: got (%0d,%0d) expected (0,0)", cur_row, cur_col); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL lf_pending: got %0d writes missing expected 0", exp_q.size()); end
  endtask

  task automatic test_last_cell();
    for (int i = 0; i < 29; i++) send(8'h0A);
    for (int i = 0; i < 39; i++) send(8'h7A);
    drain();
    total++; if (cur_row !== 5'd29 || cur_col !== 6'd39) begin bad++; $display("FAIL corner_pos: got (%0d,%0d) expected (29,39)", cur_row, cur_col); end
    wr_count = 0;
    send(8'hE1);
    wait_idle();
    total++; if (wr_count !== 41) begin bad++; $display("FAIL corner_count: got %0d expected 41", wr_count); end
    total++; if (cur_row !== 5'd0 || cur_col !== 6'd0) begin bad++; $display("FAIL corner_cursor: got (%0d,%0d) expected (0,0)", cur_row, cur_col); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL corner_pending: got %0d writes missing expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_clear();
    send(8'h0C);
    repeat (500) @(posedge clk);
    #1;
    total++; if (vram_we !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL midclr_active: got we=%b busy=%b expected 1/1", vram_we, busy); end
    reset = 1'b1;
    #1;
    total++; if (vram_we !== 1'b0 || vram_waddr !== 11'd0 || vram_wdata !== 8'h20) begin
      bad++; $display("FAIL midrst_wport: got we=%b addr=%0d data=%h expected 0/0/20", vram_we, vram_waddr, vram_wdata);
    end
    total++; if (in_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL midrst_flags: got ready=%b busy=%b expected 0/1", in_ready, busy); end
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    push_screen();
    @(posedge clk); @(posedge clk); #1;
    wr_count = 0;
    reset = 1'b0;
    wait_idle();
    total++; if (wr_count !== 1200) begin bad++; $display("FAIL refill_count: got %0d expected 1200", wr_count); end
    total++; if (last_wr - first_wr !== 1199) begin bad++; $display("FAIL refill_contig: got span %0d expected 1199", last_wr - first_wr); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL refill_pending: got %0d writes missing expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_line_wrap();
    test_controls();
    test_lf_bottom();
    test_last_cell();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
